// File: rtl/rvvi_depacketizer.sv
// Receive side of the RVVI link: checks the header of each 32-bit AXI-stream frame word, reassembles
// frame count and payload into one record, and hands complete records to a valid/ready output slot.
//
// state   | meaning
// --------+-----------------------------------------------------------
// HDR     | words 0-3, DstMac/EthType compared, mismatch accumulated
// FCNT    | frame-count words
// PAYLOAD | payload words
// HOLD    | record complete, waiting for the output slot (tready = 0)
// DROP    | discarding words of a rejected frame until tlast
module rvvi_depacketizer #(
    parameter int RVVI_WIDTH        = 784,
    parameter int FRAME_COUNT_WIDTH = 64,
    parameter int DROP_COUNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  RxAxiTdata,
    input  logic [3:0]                   RxAxiTkeep,
    input  logic                         RxAxiTvalid,
    input  logic                         RxAxiTlast,
    output logic                         RxAxiTready,
    input  logic [47:0]                  DstMac,
    input  logic [15:0]                  EthType,
    output logic [RVVI_WIDTH-1:0]        Rvvi,
    output logic [FRAME_COUNT_WIDTH-1:0] RvviFrameCount,
    output logic                         RvviValid,
    input  logic                         RvviReady,
    output logic                         SeqError,
    output logic                         FrameDropped,
    output logic [DROP_COUNT_WIDTH-1:0]  DropCount
);
    localparam int PW = (RVVI_WIDTH + 31) / 32;
    localparam int FW = FRAME_COUNT_WIDTH / 32;
    localparam int TW = 4 + FW + PW;
    localparam int CW = $clog2(TW);
    localparam logic [CW-1:0] LAST = CW'(TW - 1);

    typedef enum logic [2:0] {HDR, FCNT, PAYLOAD, HOLD, DROP} state_t;

    state_t                       state, state_next;
    logic [CW-1:0]                word_cnt, cnt_next;
    logic                         mism, mism_next;
    logic [FRAME_COUNT_WIDTH-1:0] asm_fcnt, fcnt_next, exp_count;
    logic [PW*32-1:0]             asm_pay, pay_next;
    logic                         tready_q, accept, word_mis, slot_free, drop, load;
    logic                         keep_unused;

    // Frame length comes from the word count, so tkeep carries no information here.
    assign keep_unused = ^RxAxiTkeep;
    assign RxAxiTready = tready_q;
    assign accept      = RxAxiTvalid & tready_q;
    assign slot_free   = ~RvviValid | RvviReady;

    always_comb begin
        word_mis = 1'b0;
        if (state == HDR) begin
            case (word_cnt)
                CW'(0):  word_mis = RxAxiTdata != {DstMac[23:16], DstMac[31:24], DstMac[39:32], DstMac[47:40]};
                CW'(1):  word_mis = RxAxiTdata[15:0] != {DstMac[7:0], DstMac[15:8]};
                CW'(3):  word_mis = RxAxiTdata[15:0] != {EthType[7:0], EthType[15:8]};
                default: word_mis = 1'b0;
            endcase
        end
    end

    // Assembly registers; the completing word is merged combinationally so it can load without a bubble.
    always_comb begin
        fcnt_next = asm_fcnt;
        pay_next  = asm_pay;
        for (int i = 0; i < FW; i++)
            if (accept && state == FCNT && word_cnt == CW'(4 + i))
                fcnt_next[i*32 +: 32] = RxAxiTdata;
        for (int i = 0; i < PW; i++)
            if (accept && state == PAYLOAD && word_cnt == CW'(4 + FW + i))
                pay_next[i*32 +: 32] = RxAxiTdata;
    end

    always_comb begin
        state_next = state;
        cnt_next   = word_cnt;
        mism_next  = mism;
        drop       = 1'b0;
        load       = 1'b0;
        case (state)
            HDR, FCNT, PAYLOAD: begin
                if (accept) begin
                    cnt_next = word_cnt + CW'(1);
                    if (state == HDR)
                        mism_next = mism | word_mis;
                    if (RxAxiTlast && word_cnt != LAST) begin
                        drop       = 1'b1;
                        state_next = HDR;
                        cnt_next   = '0;
                        mism_next  = 1'b0;
                    end else if (state == HDR && word_cnt == CW'(3) && (mism | word_mis)) begin
                        drop       = 1'b1;
                        state_next = DROP;
                        cnt_next   = '0;
                        mism_next  = 1'b0;
                    end else if (word_cnt == LAST) begin
                        cnt_next  = '0;
                        mism_next = 1'b0;
                        if (!RxAxiTlast) begin
                            drop       = 1'b1;
                            state_next = DROP;
                        end else if (slot_free) begin
                            load       = 1'b1;
                            state_next = HDR;
                        end else begin
                            state_next = HOLD;
                        end
                    end else if (state == HDR && word_cnt == CW'(3)) begin
                        state_next = FCNT;
                    end else if (state == FCNT && word_cnt == CW'(3 + FW)) begin
                        state_next = PAYLOAD;
                    end
                end
            end
            HOLD: begin
                if (RvviReady) begin
                    load       = 1'b1;
                    state_next = HDR;
                end
            end
            DROP: begin
                if (accept && RxAxiTlast)
                    state_next = HDR;
            end
            default: state_next = HDR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= HDR;
            word_cnt       <= '0;
            mism           <= 1'b0;
            asm_fcnt       <= '0;
            asm_pay        <= '0;
            exp_count      <= '0;
            tready_q       <= 1'b0;
            Rvvi           <= '0;
            RvviFrameCount <= '0;
            RvviValid      <= 1'b0;
            SeqError       <= 1'b0;
            FrameDropped   <= 1'b0;
            DropCount      <= '0;
        end else begin
            state        <= state_next;
            word_cnt     <= cnt_next;
            mism         <= mism_next;
            asm_fcnt     <= fcnt_next;
            asm_pay      <= pay_next;
            tready_q     <= state_next != HOLD;
            FrameDropped <= drop;
            SeqError     <= 1'b0;
            if (drop && DropCount != '1)
                DropCount <= DropCount + DROP_COUNT_WIDTH'(1);
            if (load) begin
                Rvvi           <= pay_next[RVVI_WIDTH-1:0];
                RvviFrameCount <= asm_fcnt;
                RvviValid      <= 1'b1;
                SeqError       <= asm_fcnt != exp_count;
                exp_count      <= asm_fcnt + FRAME_COUNT_WIDTH'(1);
            end else if (RvviReady) begin
                RvviValid <= 1'b0;
            end
        end
    end
endmodule
